// File: rtl/booth_seq_mult16_pkg.sv
// Shared constants and state encoding for the sequential radix-2 Booth multiplier.
package booth_seq_mult16_pkg;

    localparam int OP_W   = 16;
    localparam int PROD_W = 32;
    localparam int ITER   = 16;
    localparam int ACC_W  = OP_W + 1;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/mux16_2_to_1.sv
// 16-bit two-input multiplexer; sel_i=1 selects b_i.
module mux16_2_to_1
    import booth_seq_mult16_pkg::*;
(
    input  logic [OP_W-1:0] a_i,
    input  logic [OP_W-1:0] b_i,
    input  logic            sel_i,
    output logic [OP_W-1:0] y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/booth_seq_mult16.sv
// Sequential signed 16x16 radix-2 Booth multiplier: one Booth step per RUN cycle,
// 16 RUN cycles, one-cycle DONE pulse with a registered 32-bit product.
module booth_seq_mult16
    import booth_seq_mult16_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OP_W-1:0]   multiplicand,
    input  logic [OP_W-1:0]   multiplier,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] product
);

    state_e              state_q, state_d;
    logic [ACC_W-1:0]    a_q, a_d;
    logic [ACC_W-1:0]    m_q, m_d;
    logic [OP_W-1:0]     q_q, q_d;
    logic                q_m1_q, q_m1_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PROD_W-1:0]   product_q, product_d;

    logic [OP_W-1:0]     mux_y;
    logic [ACC_W-1:0]    addend;
    logic                carry_in;
    logic                do_add;
    logic [ACC_W-1:0]    sum;
    logic [ACC_W-1:0]    a_step;
    logic [ACC_W-1:0]    a_shift;
    logic [OP_W-1:0]     q_shift;

    mux16_2_to_1 u_addend_mux (
        .a_i   (m_q[OP_W-1:0]),
        .b_i   (~m_q[OP_W-1:0]),
        .sel_i (q_q[0]),
        .y_o   (mux_y)
    );

    // M is held sign-extended, so m_q[16]^sel equals mux_y[15]: this is the sign extension.
    assign addend   = {m_q[ACC_W-1] ^ q_q[0], mux_y};
    assign carry_in = q_q[0] & ~q_m1_q;
    assign do_add   = q_q[0] ^ q_m1_q;
    assign sum      = a_q + addend + {{(ACC_W-1){1'b0}}, carry_in};
    assign a_step   = do_add ? sum : a_q;
    assign a_shift  = {a_step[ACC_W-1], a_step[ACC_W-1:1]};
    assign q_shift  = {a_step[0], q_q[OP_W-1:1]};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output is defaulted first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        m_d       = m_q;
        q_d       = q_q;
        q_m1_d    = q_m1_q;
        count_d   = count_q;
        product_d = product_q;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    m_d     = {multiplicand[OP_W-1], multiplicand};
                    q_d     = multiplier;
                    a_d     = '0;
                    q_m1_d  = 1'b0;
                    count_d = '0;
                end
            end
            RUN: begin
                busy    = 1'b1;
                a_d     = a_shift;
                q_d     = q_shift;
                q_m1_d  = q_q[0];
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(ITER - 1)) begin
                    state_d   = DONE;
                    product_d = {a_shift[OP_W-1:0], q_shift};
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the datapath registers are reset too, so an aborted operation leaves no stale operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            m_q       <= '0;
            q_q       <= '0;
            q_m1_q    <= 1'b0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            a_q       <= a_d;
            m_q       <= m_d;
            q_q       <= q_d;
            q_m1_q    <= q_m1_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule
